float_mul_seq: RTL
==================

# float_mul_seq

Sequential single-precision floating-point multiplier for the dequantisation path of the JPEG pipeline. It multiplies quantised DCT coefficients by quantisation-table entries. It is the inverse-direction counterpart of the pipelined quantisation divider. It uses an iterative shift-and-add mantissa multiply with a blocking valid/ready input handshake, which trades throughput (one result per 26 cycles) for area.

## Interface
- No parameters. Format is fixed IEEE 754 single precision: 1b sign, 8b exponent, 23b mantissa.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- din1  in  32  operand A (IEEE 754 single).
- din2  in  32  operand B (IEEE 754 single).
- din_valid  in  1  operands valid; a transfer occurs on an edge where din_valid & din_ready.
- din_ready  out  1  block idle and able to accept operands.
- dout  out  32  product A×B, registered; holds its value between results.
- dout_valid  out  1  one-cycle pulse; dout is valid while it is high.

## Operation
- **States:** IDLE, MUL, NORM.
  - din_ready = (state == IDLE).
  - din_valid is ignored outside IDLE.
- **IDLE + transfer → MUL.** Latch the following:
  - sign = din1[31]^din2[31].
  - exp = {2'b0,din1[30:23]} + {2'b0,din2[30:23]} − 10'd127 (10-bit).
  - zero = (din1[30:23]==0) | (din2[30:23]==0).
  - mcand = {1,din1[22:0]}, mplier = {1,din2[22:0]}.
  - acc[48:0] = 0, cnt = 0.
- **MUL (24 cycles):** on each edge:
  - acc = (acc + (mplier[0] ? {1'b0,mcand,24'b0} : 0)) >> 1.
  - mplier >>= 1, cnt++.
  - After the edge with cnt==23 → NORM. acc[47:0] then holds the exact 48-bit product {1.m1}×{1.m2}.
- **NORM (1 cycle):** register dout, pulse dout_valid, → IDLE.
  - If zero: dout = 32'h0, including the sign bit (a result of −0 is never produced).
  - Else if acc[47]: dout = {sign, exp[7:0]+1, acc[46:24]}.
  - Else: dout = {sign, exp[7:0], acc[45:23]}.
- **Rounding:** round toward zero (truncation). Discarded low product bits are dropped.
- **Unsupported inputs:** denormals are treated as zero. Inf, NaN, exponent overflow and underflow are not handled. The exponent wraps modulo 256, which matches the divider's limitations.

## Timing
- **Reset:** state = IDLE, din_ready = 1, dout_valid = 0, dout = 32'h0, acc = 0, cnt = 0.
- **Reset mid-operation:** aborts the computation. No dout_valid is produced. dout keeps its reset value of 0, and din_ready = 1 in the cycle after the reset edge.
- **Latency:** transfer at edge E0. MUL edges are E1..E24 and the NORM edge is E25. dout_valid is high for exactly the one cycle following E25.
- **din_ready:** low from the cycle after E0 until the NORM edge E25. It returns high together with dout_valid, so a new transfer may occur on edge E26.
- **Throughput:** one result per 26 cycles with back-to-back input.
- **Operand capture:** operands are sampled only at the transfer edge. Changes to din1/din2 afterwards have no effect.
- **dout between results:** dout is stable except at NORM edges. dout_valid never stays high for 2 consecutive cycles.

## Test plan
- **Basic multiply and latency:** rst for 2 cycles, then din1=0x40000000 (2.0), din2=0x40400000 (3.0), din_valid=1 for 1 cycle → dout=0x40C00000 (6.0), with dout_valid exactly 26 cycles after the transfer edge and din_ready low in between.
- **Normalisation, both branches:** 0x3FC00000 × 0x3FC00000 (1.5×1.5) → 0x40100000, the acc[47]=1 branch. 0x3F800000 × 0x3F800000 → 0x3F800000, the acc[47]=0 branch.
- **Truncation and sign:**
  - 0x3FFFFFFF × 0x3FFFFFFF → 0x407FFFFE, with no round-up.
  - 0xBF800000 × 0x3F000000 (−1.0 × 0.5) → 0xBF000000.
- **Zero operand:** 0x00000000 × 0xC0A00000 → 0x00000000. A denormal 0x00000001 × 0x40000000 → 0x00000000.
- **Back-to-back and busy:**
  - Hold din_valid=1 with pair 1 (2.0×3.0), then switch to pair 2 (0x40800000×0x3E800000, 4.0×0.25) after the first transfer.
  - Required: pair 2 is accepted on the edge at the end of pair 1's dout_valid cycle, and produces 0x3F800000 26 cycles later.
  - Inputs presented while busy are not consumed.
- **Reset mid-operation:** assert rst for 1 cycle 10 cycles after a transfer → no dout_valid within 40 cycles, dout=0, din_ready=1 after the reset edge. A subsequent 2.0×3.0 gives the correct 0x40C00000.

Source files
------------

// File: rtl/float_mul_seq_if.sv
// Operand/result bus of the sequential single-precision multiplier.
// master drives operands and takes results; slave is the multiplier itself.
interface float_mul_seq_if;
  logic [31:0] din1;
  logic [31:0] din2;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] dout;
  logic        dout_valid;

  modport master (
    output din1, din2, din_valid,
    input  din_ready, dout, dout_valid
  );

  modport slave (
    input  din1, din2, din_valid,
    output din_ready, dout, dout_valid
  );
endinterface

// File: rtl/float_mul_seq.sv
// Sequential IEEE 754 single-precision multiplier for JPEG dequantisation.
// One operand pair is accepted while idle; the 24x24 mantissa product is built
// by shift-and-add over 24 cycles, then normalised and truncated in one cycle.
// Denormals count as zero; Inf/NaN and exponent over/underflow are not handled.
module float_mul_seq (
  input  logic           clk,
  input  logic           rst,
  float_mul_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_NORM
  } state_t;

  state_t      state_reg;
  logic        sign_reg;
  logic        zero_reg;
  // The exponent wraps modulo 256, so only its low 8 bits are ever needed.
  logic [7:0]  exp_reg;
  logic [23:0] mcand_reg;
  logic [23:0] mplier_reg;
  logic [48:0] acc_reg;
  logic [4:0]  cnt_reg;
  logic [31:0] dout_reg;
  logic        dout_valid_reg;

  logic [23:0] addend_bits;
  logic [48:0] acc_sum;
  logic [48:0] acc_next;
  logic [31:0] dout_next;
  logic        xfer;

  assign xfer = bus.din_valid && (state_reg == ST_IDLE);

  // Multiplicand gated by the current multiplier LSB (partial product row).
  genvar gi;
  generate
    for (gi = 0; gi < 24; gi++) begin : g_pp
      assign addend_bits[gi] = mcand_reg[gi] & mplier_reg[0];
    end
  endgenerate

  // One shift-and-add step; the partial product enters at the top of acc.
  always_comb begin
    acc_sum  = acc_reg + {1'b0, addend_bits, 24'b0};
    acc_next = acc_sum >> 1;
  end

  // Normalise the 48-bit product: bit 47 set means the product is in [2,4).
  always_comb begin
    dout_next = 32'h0;
    if (zero_reg) begin
      dout_next = 32'h0;
    end else if (acc_reg[47]) begin
      dout_next = {sign_reg, exp_reg + 8'd1, acc_reg[46:24]};
    end else begin
      dout_next = {sign_reg, exp_reg, acc_reg[45:23]};
    end
  end

  // Control FSM plus datapath registers; a reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      sign_reg       <= 1'b0;
      zero_reg       <= 1'b0;
      exp_reg        <= 8'h0;
      mcand_reg      <= 24'h0;
      mplier_reg     <= 24'h0;
      acc_reg        <= 49'h0;
      cnt_reg        <= 5'd0;
      dout_reg       <= 32'h0;
      dout_valid_reg <= 1'b0;
    end else begin
      dout_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (xfer) begin
            sign_reg   <= bus.din1[31] ^ bus.din2[31];
            exp_reg    <= bus.din1[30:23] + bus.din2[30:23] - 8'd127;
            zero_reg   <= (bus.din1[30:23] == 8'h0) || (bus.din2[30:23] == 8'h0);
            mcand_reg  <= {1'b1, bus.din1[22:0]};
            mplier_reg <= {1'b1, bus.din2[22:0]};
            acc_reg    <= 49'h0;
            cnt_reg    <= 5'd0;
            state_reg  <= ST_MUL;
          end
        end
        ST_MUL: begin
          acc_reg    <= acc_next;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd23) begin
            state_reg <= ST_NORM;
          end
        end
        ST_NORM: begin
          dout_reg       <= dout_next;
          dout_valid_reg <= 1'b1;
          state_reg      <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.din_ready  = (state_reg == ST_IDLE);
  assign bus.dout       = dout_reg;
  assign bus.dout_valid = dout_valid_reg;

endmodule
